// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin N:1 arbiter feeding a one-entry valid/ready output register.
// Define RR_ARB_FIXED_PRIO_EN to switch to fixed lowest-index-wins priority (no pointer).
module rr_arb_mux #(
    parameter int NUM_OF_INPUTS = 5,
    parameter int INPUT_WIDTH   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_OF_INPUTS-1:0]               req,
    input  logic [INPUT_WIDTH*NUM_OF_INPUTS-1:0]   data_in,
    output logic [NUM_OF_INPUTS-1:0]               ack,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [INPUT_WIDTH-1:0]                 out_data,
    output logic [$clog2(NUM_OF_INPUTS)-1:0]       out_sel
);

    localparam int N  = NUM_OF_INPUTS;
    localparam int W  = INPUT_WIDTH;
    localparam int SW = $clog2(NUM_OF_INPUTS);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic           load;
    logic [SW-1:0]  winner;
    logic [W-1:0]   win_data;

    assign out_valid = (state == FULL);
    assign load      = rst_n && (|req) && (!out_valid || out_ready);

`ifdef RR_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) winner = SW'(i);
        end
    end
`else
    logic [SW-1:0] ptr;

    // Search ptr, ptr+1, ... wrapping explicitly at N (N need not be 2^k).
    always_comb begin
        logic hit;
        int   idx;
        hit    = 1'b0;
        idx    = 0;
        winner = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!hit && req[idx]) begin
                hit    = 1'b1;
                winner = SW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= (winner == SW'(N - 1)) ? '0 : winner + 1'b1;
        end
    end
`endif

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == SW'(i)) win_data = data_in[i*W +: W];
        end
    end

    always_comb begin
        ack = '0;
        if (load) ack = N'(1) << winner;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (load) state_nxt = FULL;
            FULL: begin
                if (load)           state_nxt = FULL;
                else if (out_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out_data <= win_data;
                out_sel  <= winner;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed checks of rr_arb_mux with N=5, W=4.
// Honours RR_ARB_FIXED_PRIO_EN for the wrap-case expectations.
module tb_rr_arb_mux;

    logic        clk;
    logic        rst_n;
    logic [4:0]  req;
    logic [19:0] data_in;
    logic [4:0]  ack;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [2:0]  out_sel;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] slice [5] = '{4'h3, 4'h5, 4'hA, 4'hC, 4'hE};

    rr_arb_mux #(.NUM_OF_INPUTS(5), .INPUT_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        data_in   = {4'hE, 4'hC, 4'hA, 4'h5, 4'h3};
        req       = 5'b11111;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        chk("rst_ack",   32'(ack),       32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  32'(out_data),  32'h0);
        chk("rst_sel",   32'(out_sel),   32'h0);
        #9 rst_n = 1'b1;
        #1;
        chk("rel_ack", 32'(ack), 32'h01);
        req = 5'b00000;
        tick();

        // single requester 2
        req = 5'b00100; out_ready = 1'b1;
        #1 chk("one_ack", 32'(ack), 32'h04);
        tick();
        chk("one_valid", 32'(out_valid), 32'h1);
        chk("one_data",  32'(out_data),  32'hA);
        chk("one_sel",   32'(out_sel),   32'h2);
        req = 5'b00000;
        #1 chk("one_ack0", 32'(ack), 32'h0);
        tick();
        chk("one_drain", 32'(out_valid), 32'h0);
        chk("one_keep",  32'(out_data),  32'hA);

        rst_n = 1'b0;
        #2 rst_n = 1'b1;

        // all requesting, full throughput: 0,1,2,3,4,0,1
        req = 5'b11111; out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1 chk("rr_ack", 32'(ack), 32'(1) << (k % 5));
            tick();
            chk("rr_valid", 32'(out_valid), 32'h1);
            chk("rr_sel",   32'(out_sel),   32'(k % 5));
            chk("rr_data",  32'(out_data),  32'(slice[k % 5]));
        end

        // stall three cycles with out_sel=1
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_ack", 32'(ack), 32'h0);
            tick();
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_sel",   32'(out_sel),   32'h1);
            chk("stall_data",  32'(out_data),  32'h5);
        end
        out_ready = 1'b1;
        #1 chk("unstall_ack", 32'(ack), 32'h04);
        tick();
        chk("unstall_sel", 32'(out_sel), 32'h2);

        // wrap after grant 4
        req = 5'b10000;
        #1 chk("g4_ack", 32'(ack), 32'h10);
        tick();
        chk("g4_sel", 32'(out_sel), 32'h4);
        req = 5'b01001;
        #1 chk("wrap_ack0", 32'(ack), 32'h01);
        tick();
        chk("wrap_sel0", 32'(out_sel), 32'h0);
`ifdef RR_ARB_FIXED_PRIO_EN
        #1 chk("wrap_ack1", 32'(ack), 32'h01);
        tick();
        chk("wrap_sel1", 32'(out_sel), 32'h0);
`else
        #1 chk("wrap_ack1", 32'(ack), 32'h08);
        tick();
        chk("wrap_sel1", 32'(out_sel), 32'h3);
`endif

        // async reset while full and stalled
        req = 5'b11111; out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_data",  32'(out_data),  32'h0);
        chk("arst_sel",   32'(out_sel),   32'h0);
        chk("arst_ack",   32'(ack),       32'h0);
        #1 rst_n = 1'b1;
        req = 5'b10000; out_ready = 1'b1;
        #1 chk("post_ack", 32'(ack), 32'h10);
        tick();
        chk("post_sel",   32'(out_sel),   32'h4);
        chk("post_data",  32'(out_data),  32'hE);
        chk("post_valid", 32'(out_valid), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
